vga_sync: RTL
=============

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, system clock cycles per pixel; legal range 1..16.
REQ-002 SHALL provide ports in this order and no others:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- hsync  out  1  horizontal sync, active-low, registered.
- vsync  out  1  vertical sync, active-low, registered.
- video_on  out  1  high while the current pixel is in the 640x480 visible area.
- p_tick  out  1  one-clk pulse marking each pixel-rate advance.
- pixel_x  out  10  current horizontal count, 0..799.
- pixel_y  out  10  current vertical count, 0..524.
- frame_tick  out  1  one-clk pulse on the last pixel of each frame.

Function
REQ-003 SHALL use horizontal timing: 640 visible, 16 front porch, 96 sync, 48 back porch, 800 total.
REQ-004 SHALL use vertical timing: 480 visible, 10 front porch, 2 sync, 33 back porch, 525 total.
REQ-005 SHALL keep a divider counter of width ceil(log2(CLK_DIV)), minimum 1 bit, counting 0..CLK_DIV-1 and wrapping to 0.
REQ-006 SHALL assert p_tick in exactly the clock cycle where the divider equals CLK_DIV-1; with CLK_DIV=1, p_tick SHALL be 1 every cycle after reset.
REQ-007 SHALL change pixel_x and pixel_y only on a rising edge where p_tick is 1, and hold them otherwise.
REQ-008 SHALL increment pixel_x by 1 per p_tick, and wrap 799 -> 0 on that edge.
REQ-009 SHALL increment pixel_y by 1 only on the edge where pixel_x wraps, and wrap 524 -> 0 when pixel_x and pixel_y wrap together.
REQ-010 SHALL drive pixel_x and pixel_y directly from counter registers; values 800..1023 and 525..1023 SHALL never appear.
REQ-011 SHALL compute hsync and vsync registers from the next-count values, so hsync is 0 exactly while pixel_x is 656..751 and vsync is 0 exactly while pixel_y is 490..491, with zero cycles of skew.
REQ-012 SHALL decode video_on combinationally as (pixel_x < 640) AND (pixel_y < 480).
REQ-013 SHALL decode frame_tick combinationally as p_tick AND pixel_x==799 AND pixel_y==524: one pulse per 420000 pixel ticks.
REQ-014 SHALL present the row-481, column-0 pixel for exactly CLK_DIV clocks per frame, so downstream refresh logic keyed to (pixel_y==481 && pixel_x==0) fires once per frame.
REQ-015 SHALL not depend on downstream acknowledgement; timing is free-running with no backpressure.

Reset
REQ-016 SHALL, while reset is high, force the divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0 (CLK_DIV>=2), frame_tick=0, video_on=1.
REQ-017 SHALL apply reset asynchronously, including in mid-line or mid-sync; hsync and vsync SHALL return to 1 immediately without waiting for a clock edge.
REQ-018 SHALL, on the first rising edge after reset deasserts, begin counting from the divider's 0 state, so the first p_tick occurs at edge CLK_DIV.

Verification
REQ-019 The bench SHALL cover these scenarios:
- CLK_DIV=2, release reset -> p_tick high on every 2nd clk; pixel_x reaches 1 after 2 clks; video_on=1.
- CLK_DIV=2, run one line -> hsync low for exactly 96 pixel ticks starting when pixel_x=656; pixel_y increments to 1 when pixel_x wraps 799->0.
- CLK_DIV=2, run one full frame -> vsync low for 2 lines (pixel_y 490,491); frame_tick pulses once; its width is 1 clk; count is 840000 clks.
- CLK_DIV=1 -> p_tick constantly 1; frame period is 420000 clks; video_on is high for 307200 pixels per frame.
- Assert reset async at pixel_x=700, pixel_y=491 (both syncs low) -> hsync=1, vsync=1, counters 0 before the next edge; normal restart follows.
- CLK_DIV=4, sample pixel_x at pixel_y=481 -> (481,0) is held for exactly 4 clks per frame; pixel_x is never >799 and pixel_y is never >524.

Source files
------------

// File: rtl/vga_sync.sv
// VGA 640x480 timing generator.
// A clock divider produces the pixel-rate tick; horizontal and vertical
// counters advance on that tick. Sync outputs are registered from the
// next-count values so they line up with pixel_x/pixel_y with no skew.
module vga_sync #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  // Horizontal timing in pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;  // 640 + 16 front porch
  localparam logic [9:0] H_SYNC_END   = 10'd751;  // 96 sync pixels
  localparam logic [9:0] H_LAST       = 10'd799;  // 800 total

  // Vertical timing in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;  // 480 + 10 front porch
  localparam logic [9:0] V_SYNC_END   = 10'd491;  // 2 sync lines
  localparam logic [9:0] V_LAST       = 10'd524;  // 525 total

  // Divider width: at least one bit so CLK_DIV=1 still has a legal register
  localparam int              DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;

  // Divider wraps at CLK_DIV-1; with CLK_DIV=1 it stays at 0
  always_comb begin
    div_next = div_cnt;
    if (div_cnt == DIV_MAX) begin
      div_next = '0;
    end else begin
      div_next = div_cnt + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Pixel tick is the last divider state, so the first tick lands on edge CLK_DIV
  always_comb begin
    p_tick = (div_cnt == DIV_MAX);
  end

  // Next pixel position: advance only on a tick, wrap line and frame
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_LAST) begin
        x_next = 10'd0;
        if (pixel_y == V_LAST) begin
          y_next = 10'd0;
        end else begin
          y_next = pixel_y + 10'd1;
        end
      end else begin
        x_next = pixel_x + 10'd1;
        y_next = pixel_y;
      end
    end else begin
      x_next = pixel_x;
      y_next = pixel_y;
    end
  end

  // Divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_next;
    end
  end

  // Counters and syncs; syncs use the next counts so they change with the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x <= 10'd0;
      pixel_y <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= !((x_next >= H_SYNC_START) && (x_next <= H_SYNC_END));
      vsync   <= !((y_next >= V_SYNC_START) && (y_next <= V_SYNC_END));
    end
  end

  // Visible-area and end-of-frame decodes
  always_comb begin
    video_on   = (pixel_x < H_VISIBLE) && (pixel_y < V_VISIBLE);
    frame_tick = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);
  end

endmodule
